// File: rtl/drain_pkg.sv
// rtl/drain_pkg.sv - shared state encoding and default widths for drain_counter
package drain_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        HALT   = 2'd2
    } drain_state_e;

    localparam int DRAIN_WIDTH  = 16;
    localparam int DRAIN_STEP_W = 4;
    localparam int DRAIN_CNT_W  = 8;

endpackage

// File: rtl/debit_subtractor.sv
// rtl/debit_subtractor.sv - one-bit-wider balance minus debit; the top bit is the borrow
module debit_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] balance,
    input  logic [WIDTH-1:0] debit_ext,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
);

    always_comb begin
        {borrow, difference} = {1'b0, balance} - {1'b0, debit_ext};
    end

endmodule

// File: rtl/drain_counter.sv
// rtl/drain_counter.sv - down-counting balance drained by debits; DRAIN_SATURATE_EN selects over-debit handling
module drain_counter
    import drain_pkg::*;
#(
    parameter int WIDTH  = DRAIN_WIDTH,
    parameter int STEP_W = DRAIN_STEP_W,
    parameter int CNT_W  = DRAIN_CNT_W
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              Load,
    input  logic [WIDTH-1:0]  LOAD,
    input  logic              debit_valid,
    input  logic [STEP_W-1:0] debit,
    output logic              debit_ready,
    output logic [WIDTH-1:0]  Out,
    output logic              zero,
    output logic              underflow,
    output logic [CNT_W-1:0]  debit_cnt
);

    drain_state_e     state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uf_q, uf_d;

    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    debit_subtractor #(.WIDTH(WIDTH)) u_sub (
        .balance    (out_q),
        .debit_ext  ({{(WIDTH-STEP_W){1'b0}}, debit}),
        .difference (diff),
        .borrow     (borrow)
    );

    assign debit_ready = (state_q == ACTIVE) && !Load;
    assign accept      = debit_valid && debit_ready;
    assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        uf_d    = uf_q;
        if (Load) begin
            out_d   = LOAD;
            cnt_d   = '0;
            uf_d    = 1'b0;
            state_d = (LOAD != '0) ? ACTIVE : EMPTY;
        end else if (accept) begin
            if (!borrow) begin
                out_d = diff;
                cnt_d = cnt_inc;
                if (diff == '0) state_d = EMPTY;
            end else begin
                uf_d = 1'b1;
`ifdef DRAIN_SATURATE_EN
                out_d   = '0;
                cnt_d   = cnt_inc;
                state_d = EMPTY;
`else
                state_d = HALT;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            cnt_q   <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            uf_q    <= uf_d;
        end
    end

    assign Out       = out_q;
    assign zero      = (out_q == '0);
    assign underflow = uf_q;
    assign debit_cnt = cnt_q;

endmodule

// File: tb/tb_drain_counter.sv
// tb/tb_drain_counter.sv - randomized and directed self-checking bench for drain_counter
module tb_drain_counter;

    logic        clk;
    logic        Rst;
    logic        Load;
    logic [15:0] LOAD;
    logic        debit_valid;
    logic [3:0]  debit;
    logic        debit_ready;
    logic [15:0] Out;
    logic        zero;
    logic        underflow;
    logic [7:0]  debit_cnt;

    int checks   = 0;
    int failures = 0;

    localparam int EMP = 0, ACT = 1, HLT = 2;
    int m_bal, m_cnt, m_uf, m_st;

    drain_counter dut (
        .clk         (clk),
        .Rst         (Rst),
        .Load        (Load),
        .LOAD        (LOAD),
        .debit_valid (debit_valid),
        .debit       (debit),
        .debit_ready (debit_ready),
        .Out         (Out),
        .zero        (zero),
        .underflow   (underflow),
        .debit_cnt   (debit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bal = 0; m_cnt = 0; m_uf = 0; m_st = EMP;
    endtask

    task automatic check_outputs();
        check("Out", 32'(Out), 32'(m_bal));
        check("zero", 32'(zero), 32'(m_bal == 0));
        check("underflow", 32'(underflow), 32'(m_uf));
        check("debit_cnt", 32'(debit_cnt), 32'(m_cnt));
    endtask

    task automatic cycle(input bit ld, input int lv, input bit vl, input int d);
        logic [15:0] lv16;
        logic [3:0]  d4;
        lv16 = lv[15:0];
        d4   = d[3:0];
        @(negedge clk);
        Load = ld; LOAD = lv16; debit_valid = vl; debit = d4;
        #1 check("debit_ready", 32'(debit_ready), 32'(m_st == ACT && !ld));
        @(posedge clk);
        if (ld) begin
            m_bal = int'(lv16); m_cnt = 0; m_uf = 0;
            m_st = (lv16 != 0) ? ACT : EMP;
        end else if (vl && m_st == ACT) begin
            if (int'(d4) <= m_bal) begin
                m_bal = m_bal - int'(d4);
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                if (m_bal == 0) m_st = EMP;
            end else begin
                m_uf = 1;
`ifdef DRAIN_SATURATE_EN
                m_bal = 0;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_st  = EMP;
`else
                m_st = HLT;
`endif
            end
        end
        #1 check_outputs();
    endtask

    initial begin
        Rst = 1'b0; Load = 1'b0; LOAD = '0; debit_valid = 1'b0; debit = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(debit_ready), 32'd0);
        check_outputs();
        Rst = 1'b1;

        // drain 0x10 in four debits of 4
        cycle(1, 16'h0010, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 4);
        check("drain_out", 32'(Out), 32'h0);
        check("drain_cnt", 32'(debit_cnt), 32'd4);
        cycle(0, 0, 1, 4);

        // over-debit then recovery
        cycle(1, 16'h0003, 0, 0);
        cycle(0, 0, 1, 5);
        cycle(0, 0, 1, 1);
        cycle(1, 16'h0020, 0, 0);
        check("recover_out", 32'(Out), 32'h20);

        // Load colliding with a valid debit
        cycle(1, 16'h0100, 1, 15);
        check("collide_out", 32'(Out), 32'h100);

        // counter saturation with zero debits
        cycle(1, 16'h0001, 0, 0);
        for (int i = 0; i < 300; i++) cycle(0, 0, 1, 0);
        check("sat_cnt", 32'(debit_cnt), 32'hFF);
        cycle(0, 0, 0, 0);

        // asynchronous reset between edges
        cycle(1, 16'h0010, 0, 0);
        cycle(0, 0, 1, 4);
        cycle(0, 0, 1, 4);
        @(negedge clk);
        Load = 1'b0; debit_valid = 1'b1; debit = 4'd1;
        #2 Rst = 1'b0;
        #1 check("async_out", 32'(Out), 32'h0);
        check("async_ready", 32'(debit_ready), 32'd0);
        model_reset();
        @(negedge clk);
        debit_valid = 1'b0;
        Rst = 1'b1;
        check_outputs();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit ld, vl;
            int lv, d;
            ld = ($urandom_range(0, 15) == 0);
            lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 40));
            vl = ($urandom_range(0, 3) != 0);
            d  = int'($urandom_range(0, 15));
            cycle(ld, lv, vl, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
